// File: rtl/cache_arbiter_if.sv
// Line-port bundle between the two L1 caches, the arbiter and the cacheline
// adaptor. The slave modport is the arbiter's view; the master modport is
// the view of everything around it (both caches plus the adaptor).
interface cache_arbiter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
);
  // I-cache side (read-only requester)
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic                  i_pmem_read;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  // D-cache side (read and writeback)
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  // Adaptor side
  logic [ADDR_WIDTH-1:0] adp_address;
  logic                  adp_read;
  logic                  adp_write;
  logic [LINE_WIDTH-1:0] adp_wdata;
  logic [LINE_WIDTH-1:0] adp_rdata;
  logic                  adp_resp;

  modport slave (
    input  i_pmem_address, i_pmem_read,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output adp_address, adp_read, adp_write, adp_wdata,
    input  adp_rdata, adp_resp
  );

  modport master (
    output i_pmem_address, i_pmem_read,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  adp_address, adp_read, adp_write, adp_wdata,
    output adp_rdata, adp_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-way arbiter sharing the single cacheline adaptor between the I-cache
// and the D-cache. One line transaction at a time, round-robin on ties, the
// granted request is latched and held until the adaptor responds, and the
// response is steered back to the owner only.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  state_e                state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] adp_address_q, adp_address_d;
  logic                  adp_read_q, adp_read_d;
  logic                  adp_write_q, adp_write_d;
  logic [LINE_WIDTH-1:0] adp_wdata_q, adp_wdata_d;

  logic i_req;
  logic d_req;
  logic pick_d;
  logic i_done;
  logic d_done;

  // Request decode: D wins when it is alone or when I was served last.
  always_comb begin
    i_req  = bus.i_pmem_read;
    d_req  = bus.d_pmem_read | bus.d_pmem_write;
    pick_d = d_req && (!i_req || (last_grant_q == GRANT_I));
    i_done = (state_q == I_BUSY) && bus.adp_resp;
    d_done = (state_q == D_BUSY) && bus.adp_resp;
  end

  // Next-state and grant latching; the downstream request is frozen while busy.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    adp_address_d = adp_address_q;
    adp_read_d    = adp_read_q;
    adp_write_d   = adp_write_q;
    adp_wdata_d   = adp_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d       = D_BUSY;
          last_grant_d  = GRANT_D;
          adp_address_d = bus.d_pmem_address;
          adp_write_d   = bus.d_pmem_write;
          adp_read_d    = !bus.d_pmem_write;
          adp_wdata_d   = bus.d_pmem_wdata;
        end else if (i_req) begin
          state_d       = I_BUSY;
          last_grant_d  = GRANT_I;
          adp_address_d = bus.i_pmem_address;
          adp_write_d   = 1'b0;
          adp_read_d    = 1'b1;
          adp_wdata_d   = '0;
        end
      end
      I_BUSY, D_BUSY: begin
        if (bus.adp_resp) begin
          state_d     = IDLE;
          adp_read_d  = 1'b0;
          adp_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        adp_read_d  = 1'b0;
        adp_write_d = 1'b0;
      end
    endcase
  end

  // State and registered adaptor outputs with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: the 256-bit wdata register is reset too, because the adaptor must see zero after reset.
      state_q       <= IDLE;
      last_grant_q  <= GRANT_I;
      adp_address_q <= '0;
      adp_read_q    <= 1'b0;
      adp_write_q   <= 1'b0;
      adp_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      adp_address_q <= adp_address_d;
      adp_read_q    <= adp_read_d;
      adp_write_q   <= adp_write_d;
      adp_wdata_q   <= adp_wdata_d;
    end
  end

  assign bus.adp_address  = adp_address_q;
  assign bus.adp_read     = adp_read_q;
  assign bus.adp_write    = adp_write_q;
  assign bus.adp_wdata    = adp_wdata_q;

  // Zero-latency return path, visible only to the current owner.
  assign bus.i_pmem_resp  = i_done;
  assign bus.d_pmem_resp  = d_done;
  assign bus.i_pmem_rdata = i_done ? bus.adp_rdata : '0;
  assign bus.d_pmem_rdata = d_done ? bus.adp_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios with literal
// expectations, then randomized caches and adaptor checked every cycle
// against a transaction-level model of who owns the adaptor.
module tb_cache_arbiter;

  typedef enum logic [1:0] {NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} own_e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_arbiter_if #(.LINE_WIDTH(256), .ADDR_WIDTH(32)) bus ();

  cache_arbiter #(.LINE_WIDTH(256), .ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  own_e         m_owner = NONE;
  own_e         m_last  = OWN_I;
  logic [31:0]  m_addr  = '0;
  logic         m_write = 1'b0;
  logic [255:0] m_wdata = '0;
  bit           m_i_done = 1'b0;
  bit           m_d_done = 1'b0;
  own_e         grant_log[$];

  always @(posedge clk) begin
    bit   i_want;
    bit   d_want;
    own_e winner;
    m_i_done = 1'b0;
    m_d_done = 1'b0;
    if (rst) begin
      m_owner = NONE;
      m_last  = OWN_I;
    end else if (m_owner == NONE) begin
      i_want = bus.i_pmem_read;
      d_want = bus.d_pmem_read || bus.d_pmem_write;
      winner = NONE;
      if (i_want && d_want) winner = (m_last == OWN_I) ? OWN_D : OWN_I;
      else if (d_want)      winner = OWN_D;
      else if (i_want)      winner = OWN_I;
      if (winner == OWN_D) begin
        m_addr  = bus.d_pmem_address;
        m_write = bus.d_pmem_write;
        m_wdata = bus.d_pmem_wdata;
      end else if (winner == OWN_I) begin
        m_addr  = bus.i_pmem_address;
        m_write = 1'b0;
        m_wdata = '0;
      end
      if (winner != NONE) begin
        m_last = winner;
        grant_log.push_back(winner);
      end
      m_owner = winner;
    end else if (bus.adp_resp) begin
      if (m_owner == OWN_I) m_i_done = 1'b1;
      else                  m_d_done = 1'b1;
      m_owner = NONE;
    end
  end

  // ---------------- per-cycle compare, mid-cycle ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      bit i_fin;
      bit d_fin;
      i_fin = (m_owner == OWN_I) && bus.adp_resp;
      d_fin = (m_owner == OWN_D) && bus.adp_resp;
      check("adp_read",  bus.adp_read,  (m_owner != NONE) && !m_write);
      check("adp_write", bus.adp_write, (m_owner != NONE) &&  m_write);
      check("i_resp",    bus.i_pmem_resp, i_fin);
      check("d_resp",    bus.d_pmem_resp, d_fin);
      check("i_rdata",   bus.i_pmem_rdata, i_fin ? bus.adp_rdata : 256'd0);
      check("d_rdata",   bus.d_pmem_rdata, d_fin ? bus.adp_rdata : 256'd0);
      if (m_owner != NONE) begin
        check("adp_address", bus.adp_address, m_addr);
        check("adp_wdata",   bus.adp_wdata,   m_wdata);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    return a & 32'hFFFF_FFE0;
  endfunction

  // Wait lat cycles, then present an adaptor response in the current cycle.
  task automatic serve(input int lat, input logic [255:0] line);
    repeat (lat) tick();
    bus.adp_rdata = line;
    bus.adp_resp  = 1'b1;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] line;
    logic [255:0] a5_line;
    int           base;
    int           lat;
    own_e         exp_g;

    bus.i_pmem_address = '0;
    bus.i_pmem_read    = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_wdata   = '0;
    bus.adp_rdata      = '0;
    bus.adp_resp       = 1'b0;
    a5_line            = {32{8'hA5}};

    // Reset state
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_adp_read",    bus.adp_read, 1'b0);
    check("reset_adp_write",   bus.adp_write, 1'b0);
    check("reset_adp_address", bus.adp_address, 32'd0);
    check("reset_adp_wdata",   bus.adp_wdata, 256'd0);
    rst = 1'b0;

    // Lone I read
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_0060;
    tick();
    check("loneI_adp_read", bus.adp_read, 1'b1);
    check("loneI_addr",     bus.adp_address, 32'h0000_0060);
    line = rand_line();
    serve(5, line);
    check("loneI_resp",   bus.i_pmem_resp, 1'b1);
    check("loneI_rdata",  bus.i_pmem_rdata, line);
    check("loneI_d_resp", bus.d_pmem_resp, 1'b0);
    tick();
    bus.adp_resp    = 1'b0;
    bus.i_pmem_read = 1'b0;
    tick();

    // D writeback
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 32'h0000_1F80;
    bus.d_pmem_wdata   = a5_line;
    tick();
    check("wb_adp_write", bus.adp_write, 1'b1);
    check("wb_adp_read",  bus.adp_read, 1'b0);
    check("wb_wdata",     bus.adp_wdata, a5_line);
    check("wb_addr",      bus.adp_address, 32'h0000_1F80);
    serve(4, rand_line());
    check("wb_d_resp", bus.d_pmem_resp, 1'b1);
    check("wb_i_resp", bus.i_pmem_resp, 1'b0);
    tick();
    bus.adp_resp     = 1'b0;
    bus.d_pmem_write = 1'b0;
    tick();

    // Reset mid-transaction, then a tie straight after reset
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_0200;
    tick();
    check("mid_busy_read", bus.adp_read, 1'b1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    bus.i_pmem_read = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rst_read",  bus.adp_read, 1'b0);
    check("mid_rst_write", bus.adp_write, 1'b0);
    bus.adp_resp       = 1'b1;
    bus.adp_rdata      = rand_line();
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_0300;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h0000_0400;
    #1;
    check("idle_resp_i_ignored", bus.i_pmem_resp, 1'b0);
    check("idle_resp_d_ignored", bus.d_pmem_resp, 1'b0);
    tick();
    bus.adp_resp = 1'b0;
    check("tie_d_first_read", bus.adp_read, 1'b1);
    check("tie_d_first_addr", bus.adp_address, 32'h0000_0400);
    line = rand_line();
    serve(2, line);
    check("tie_d_resp",  bus.d_pmem_resp, 1'b1);
    check("tie_d_rdata", bus.d_pmem_rdata, line);
    check("tie_i_rdata", bus.i_pmem_rdata, 256'd0);
    tick();
    bus.adp_resp    = 1'b0;
    bus.d_pmem_read = 1'b0;
    check("tie_gap_idle", bus.adp_read, 1'b0);
    tick();
    check("tie_i_second_read", bus.adp_read, 1'b1);
    check("tie_i_second_addr", bus.adp_address, 32'h0000_0300);
    serve(1, rand_line());
    check("tie_i_resp", bus.i_pmem_resp, 1'b1);
    tick();
    bus.adp_resp    = 1'b0;
    bus.i_pmem_read = 1'b0;
    tick();

    // Continuous contention: six transactions, both re-request at once
    base = grant_log.size();
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = rand_addr();
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = rand_addr();
    tick();
    for (int n = 0; n < 6; n++) begin
      serve($urandom_range(0, 4), rand_line());
      tick();
      bus.adp_resp = 1'b0;
      if (n == 5) begin
        bus.i_pmem_read = 1'b0;
        bus.d_pmem_read = 1'b0;
      end else if (m_i_done) begin
        bus.i_pmem_read = 1'b0;
      end else begin
        bus.d_pmem_read = 1'b0;
      end
      tick();
      if (n != 5) begin
        bus.i_pmem_read    = 1'b1;
        bus.d_pmem_read    = 1'b1;
        bus.i_pmem_address = rand_addr();
        bus.d_pmem_address = rand_addr();
      end
    end
    check("contention_grant_count", grant_log.size() - base, 6);
    for (int n = 0; n < 6; n++) begin
      exp_g = (n % 2 == 0) ? OWN_D : OWN_I;
      if (base + n < grant_log.size()) check("contention_order", grant_log[base+n], exp_g);
    end

    // Requester inputs changing while D is busy
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h0000_0A00;
    tick();
    bus.d_pmem_address = 32'h0000_0B00;
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_0C00;
    tick();
    check("busy_addr_held", bus.adp_address, 32'h0000_0A00);
    check("busy_read_held", bus.adp_read, 1'b1);
    serve(2, rand_line());
    check("busy_d_resp",  bus.d_pmem_resp, 1'b1);
    check("busy_i_waits", bus.i_pmem_resp, 1'b0);
    tick();
    bus.adp_resp    = 1'b0;
    bus.d_pmem_read = 1'b0;
    tick();
    check("busy_i_after_addr", bus.adp_address, 32'h0000_0C00);
    serve(0, rand_line());
    tick();
    bus.adp_resp    = 1'b0;
    bus.i_pmem_read = 1'b0;
    tick();

    // Randomized caches and adaptor; the compare process checks each cycle
    lat = $urandom_range(0, 6);
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (bus.i_pmem_read) begin
        if (m_i_done) bus.i_pmem_read = 1'b0;
        else if (m_owner == OWN_I && $urandom_range(0, 3) == 0) bus.i_pmem_address = rand_addr();
      end else if ($urandom_range(0, 3) == 0) begin
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = rand_addr();
      end
      if (bus.d_pmem_read || bus.d_pmem_write) begin
        if (m_d_done) begin
          bus.d_pmem_read  = 1'b0;
          bus.d_pmem_write = 1'b0;
        end else if (m_owner == OWN_D && $urandom_range(0, 3) == 0) begin
          bus.d_pmem_address = rand_addr();
          bus.d_pmem_wdata   = rand_line();
        end
      end else if ($urandom_range(0, 3) == 0) begin
        int op;
        op = $urandom_range(0, 2);
        bus.d_pmem_read    = (op != 1);
        bus.d_pmem_write   = (op != 0);
        bus.d_pmem_address = rand_addr();
        bus.d_pmem_wdata   = rand_line();
      end
      if (m_owner != NONE) begin
        if (lat == 0) begin
          bus.adp_resp  = 1'b1;
          bus.adp_rdata = rand_line();
          lat = $urandom_range(0, 6);
        end else begin
          bus.adp_resp = 1'b0;
          lat--;
        end
      end else begin
        bus.adp_resp  = ($urandom_range(0, 7) == 0);
        bus.adp_rdata = rand_line();
      end
    end

    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates between the instruction cache and the data cache for the single 256-bit line port of the `cacheline_adaptor`, which serves as the shared path to physical memory. It sits between the two L1 caches and the adaptor:
- It grants one line transaction at a time, with round-robin priority on ties.
- It holds the granted request stable until the adaptor responds.
- It routes the response and read data back to the owner only.

## Interface
Parameters:
- `LINE_WIDTH`, 256, cacheline width in bits.
- `ADDR_WIDTH`, 32, physical address width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_pmem_address`  in  ADDR_WIDTH  I-cache line address.
- `i_pmem_read`  in  1  I-cache line read request (I-cache never writes).
- `i_pmem_rdata`  out  LINE_WIDTH  line data to I-cache.
- `i_pmem_resp`  out  1  completion pulse to I-cache.
- `d_pmem_address`  in  ADDR_WIDTH  D-cache line address.
- `d_pmem_read`  in  1  D-cache line read request.
- `d_pmem_write`  in  1  D-cache line writeback request.
- `d_pmem_wdata`  in  LINE_WIDTH  D-cache writeback data.
- `d_pmem_rdata`  out  LINE_WIDTH  line data to D-cache.
- `d_pmem_resp`  out  1  completion pulse to D-cache.
- `adp_address`  out  ADDR_WIDTH  to adaptor `address_i`.
- `adp_read`  out  1  to adaptor `read_i`.
- `adp_write`  out  1  to adaptor `write_i`.
- `adp_wdata`  out  LINE_WIDTH  to adaptor `line_i`.
- `adp_rdata`  in  LINE_WIDTH  from adaptor `line_o`.
- `adp_resp`  in  1  from adaptor `resp_o`.

## Operation
- State machine: IDLE, I_BUSY, D_BUSY. A `last_grant` register holds I or D.
- IDLE, with pending requests decided as follows:
  - Only I pending (`i_pmem_read`) -> I_BUSY.
  - Only D pending (`d_pmem_read | d_pmem_write`) -> D_BUSY.
  - Both pending -> grant the requester that is not `last_grant`.
  - Neither pending -> stay in IDLE.
- On grant, the following registers latch from the winning requester:
  - `adp_address`.
  - The operation: read or write. For D, a write takes precedence if read and write are both high.
  - `adp_wdata`: D wdata on a D grant, zero on an I grant.
- `last_grant` updates to the winner on the grant edge.
- In a BUSY state:
  - `adp_read`/`adp_write` reflect the latched operation and stay constant until `adp_resp`.
  - Requester input changes are ignored.
- When `adp_resp`=1 in X_BUSY:
  - `X_pmem_resp`=1 combinationally in the same cycle.
  - `X_pmem_rdata`=`adp_rdata` in the same cycle.
  - Next state is IDLE.
  - `adp_read`/`adp_write` deassert on the next cycle.
- The non-owner always sees resp=0 and rdata=0. In IDLE both see resp=0 and rdata=0.
- `adp_resp` in IDLE is ignored: no requester resp, no state change.
- Requester contract: a request is held high until its resp and dropped in the cycle after resp. After resp, the arbiter returns to IDLE and re-samples.
- Reset:
  - State returns to IDLE and `last_grant` returns to I, so the first tie after reset goes to D.
  - `adp_read`, `adp_write`, `adp_address` and `adp_wdata` are 0.
  - Both resp outputs are 0 and both rdata outputs are 0.
  - A reset mid-transaction aborts the transaction without any resp. The adaptor shares `rst`.

## Timing
- Request seen in IDLE at cycle t -> `adp_read`/`adp_write` asserted from t+1. Arbitration latency is 1 cycle.
- `adp_resp` at cycle t+k -> requester resp at t+k, a 0-cycle return path.
- State is IDLE at t+k+1. The earliest next downstream request is t+k+2, giving 1 idle cycle between back-to-back transactions.
- `adp_address`, `adp_wdata` and the operation bits are driven from registers, glitch-free and stable for the whole BUSY period.
- Resp outputs pulse for exactly 1 cycle per adaptor resp.

## Test plan
- Lone I read:
  - Stimulus: reset; `i_pmem_read`=1, addr 0x0000_0060; adaptor returns a line after 6 cycles.
  - Response: `adp_read`=1 at t+1 with addr 0x60; `i_pmem_resp` pulses once; `i_pmem_rdata` equals the line; `d_pmem_resp` stays 0.
- D writeback:
  - Stimulus: `d_pmem_write`=1, addr 0x0000_1F80, wdata 256'hA5…A5.
  - Response: `adp_write`=1, `adp_wdata`=A5…A5 held stable until resp; `d_pmem_resp` 1 pulse; `adp_read` never asserts.
- Simultaneous requests right after reset:
  - Stimulus: I and D both request in the same cycle.
  - Response: D is served first; I is granted at D's resp +2 cycles; I's downstream address equals I's address.
- Continuous contention:
  - Stimulus: both caches re-request immediately after every resp, for 6 transactions.
  - Response: grants alternate D,I,D,I,D,I; no requester waits more than one other transaction.
- Input changes during BUSY:
  - Stimulus: during D_BUSY, change `d_pmem_address` and raise `i_pmem_read`.
  - Response: `adp_address` stays at the latched value; I is not served until D completes.
- Reset mid-transaction:
  - Stimulus: assert `rst` 3 cycles into I_BUSY.
  - Response: next cycle `adp_read`=0, both resp=0, state IDLE; a tie immediately after reset goes to D.
